// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline definitions: forwarding select codes, shadow-stage record, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // ALU operand select encoding consumed by the execute-stage operand muxes
  localparam logic [1:0] FWD_REG   = 2'd0;  // register file value (BusA/BusB)
  localparam logic [1:0] FWD_EXMEM = 2'd1;  // prior ALU result (instruction one ahead)
  localparam logic [1:0] FWD_MEMWB = 2'd2;  // writeback value (instruction two ahead)

  // Controller FSM encoding
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_FROZEN   = 2'd2;

  // Shadow copy of the write-control carried by one pipeline stage
  typedef struct packed {
    logic       valid;
    logic [4:0] rw;
    logic       regwrite;
    logic       memtoreg;
  } shadow_t;

  // A stage produces a forwardable result only if it really writes a non-$0 register
  function automatic logic isWriter(input shadow_t s);
    return s.valid && s.regwrite && (s.rw != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage decode fields in, forwarding/stall controls and perf counters out.
// Latency: n/a (signal bundle only).
// Backpressure: stall_ifid/freeze tell the pipeline to hold; no handshake otherwise.
interface fwd_hazard_ctrl_if #(parameter int CNT_W = 32);

  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_alusrc;
  logic [4:0]       id_rw;
  logic             id_regwrite;
  logic             id_memtoreg;
  logic             mem_busy;

  logic [1:0]       aluselectA;
  logic [1:0]       aluselectB;
  logic             stall_ifid;
  logic             bubble_idex;
  logic             freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  // Pipeline side: drives decode fields, consumes controls
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_alusrc,
           id_rw, id_regwrite, id_memtoreg, mem_busy,
    input  aluselectA, aluselectB, stall_ifid, bubble_idex, freeze,
           stall_cnt, freeze_cnt
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_alusrc,
           id_rw, id_regwrite, id_memtoreg, mem_busy,
    output aluselectA, aluselectB, stall_ifid, bubble_idex, freeze,
           stall_cnt, freeze_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl_match.sv
// Picks the forwarding source for one ALU operand from the EX/MEM shadows.
// Latency: combinational.
// Backpressure: none; loadHit flags a match on a load still in EX.
module fwd_match
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       useSrc,
  input  shadow_t    exStage,
  input  shadow_t    memStage,
  output logic [1:0] sel,
  output logic       loadHit
);

  logic exHit;
  logic memHit;

  assign exHit   = useSrc && isWriter(exStage)  && (exStage.rw  == src);
  assign memHit  = useSrc && isWriter(memStage) && (memStage.rw == src);
  assign loadHit = exHit && exStage.memtoreg;

  // Newest producer wins: EX result beats the older MEM result
  always_comb begin
    sel = FWD_REG;
    if (exHit)       sel = FWD_EXMEM;
    else if (memHit) sel = FWD_MEMWB;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding selects, load-use stall/bubble and memory freeze for the 5-stage pipe.
// Latency: selects registered on the ID->EX advance; stall/bubble/freeze combinational.
// Backpressure: mem_busy holds every shadow, select, FSM state; load-use stalls IF/ID 1 cycle.
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Only EX and MEM producers can be forwarded; the register file is written
  // before it is read, so an instruction retiring in WB needs no tracking.
  shadow_t          exStage;
  shadow_t          memStage;
  shadow_t          idShadow;
  logic [1:0]       selA;
  logic [1:0]       selB;
  logic             hitA;
  logic             hitB;
  logic             loadUse;
  logic             stallNow;
  logic [1:0]       aluSelA;
  logic [1:0]       aluSelB;
  logic [1:0]       state;
  logic [1:0]       savedState;
  logic [1:0]       baseState;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] freezeCnt;

  fwd_match uMatchA (
    .src      (bus.id_rs),
    .useSrc   (bus.id_use_rs),
    .exStage  (exStage),
    .memStage (memStage),
    .sel      (selA),
    .loadHit  (hitA)
  );

  // Operand B reads rt only when the immediate has not replaced it
  fwd_match uMatchB (
    .src      (bus.id_rt),
    .useSrc   (bus.id_use_rt & ~bus.id_alusrc),
    .exStage  (exStage),
    .memStage (memStage),
    .sel      (selB),
    .loadHit  (hitB)
  );

  assign loadUse  = bus.id_valid & (hitA | hitB);
  assign stallNow = rst_n & ~bus.mem_busy & loadUse;

  assign bus.stall_ifid  = stallNow;
  assign bus.bubble_idex = stallNow;
  assign bus.freeze      = bus.mem_busy;
  assign bus.aluselectA  = aluSelA;
  assign bus.aluselectB  = aluSelB;
  assign bus.stall_cnt   = stallCnt;
  assign bus.freeze_cnt  = freezeCnt;

  // Record entering EX: the ID instruction, or a bubble while a load-use stall is active
  always_comb begin
    idShadow          = '0;
    idShadow.valid    = bus.id_valid & ~loadUse;
    idShadow.rw       = bus.id_rw;
    idShadow.regwrite = bus.id_regwrite;
    idShadow.memtoreg = bus.id_memtoreg;
  end

  // After a freeze the controller resumes from whatever state it was in on entry
  always_comb begin
    baseState = (state == ST_FROZEN) ? savedState : state;
  end

  // Advance the shadow pipe and latch the selects for the instruction entering EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exStage  <= '0;
      memStage <= '0;
      aluSelA  <= FWD_REG;
      aluSelB  <= FWD_REG;
    end else if (!bus.mem_busy) begin
      exStage  <= idShadow;
      memStage <= exStage;
      aluSelA  <= idShadow.valid ? selA : FWD_REG;
      aluSelB  <= idShadow.valid ? selB : FWD_REG;
    end
  end

  // RUN / LU_STALL / FROZEN sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      savedState <= ST_RUN;
    end else if (bus.mem_busy) begin
      if (state != ST_FROZEN) savedState <= state;
      state <= ST_FROZEN;
    end else begin
      case (baseState)
        ST_RUN:      state <= loadUse ? ST_LU_STALL : ST_RUN;
        ST_LU_STALL: state <= ST_RUN;
        default:     state <= ST_RUN;
      endcase
    end
  end

  // Performance counters, free-running modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt  <= '0;
      freezeCnt <= '0;
    end else if (bus.mem_busy) begin
      freezeCnt <= freezeCnt + CNT_ONE;
    end else if (baseState == ST_LU_STALL) begin
      stallCnt <= stallCnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed pipeline sequences plus a randomized run against an issue-history model.
// Latency: selects checked 1 ns after the advancing edge; combinational outputs mid-cycle.
// Backpressure: bench re-presents the ID instruction while stalled or frozen.
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       alusrc;
    logic [4:0] rw;
    logic       wr;
    logic       ld;
  } instr_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rw;
    logic       wr;
    logic       ld;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;
  rec_t hist[$];   // hist[0] = most recently issued into EX, hist[1] = the one before

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.CNT_W(32)) dut_if ();

  fwd_hazard_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return '{valid:1'b1, rs:rs, rt:rt, urs:1'b1, urt:1'b1, alusrc:1'b0, rw:rd, wr:1'b1, ld:1'b0};
  endfunction

  function automatic instr_t immOp(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return '{valid:1'b1, rs:rs, rt:rt, urs:1'b1, urt:1'b1, alusrc:1'b1, rw:rd, wr:1'b1, ld:1'b0};
  endfunction

  function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] base);
    return '{valid:1'b1, rs:base, rt:5'd0, urs:1'b1, urt:1'b0, alusrc:1'b1, rw:rd, wr:1'b1, ld:1'b1};
  endfunction

  function automatic instr_t noInstr();
    return '0;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    i.valid  = ($urandom_range(0, 7) != 0);
    i.rs     = 5'($urandom_range(0, 5));
    i.rt     = 5'($urandom_range(0, 5));
    i.urs    = 1'($urandom_range(0, 1));
    i.urt    = 1'($urandom_range(0, 1));
    i.alusrc = 1'($urandom_range(0, 1));
    i.rw     = 5'($urandom_range(0, 5));
    i.wr     = ($urandom_range(0, 3) != 0);
    i.ld     = 1'($urandom_range(0, 1));
    return i;
  endfunction

  // Reference rules: a producer supplies register r when it is real, writes, and r is not $0
  function automatic bit writes(input rec_t p, input logic [4:0] r);
    return p.valid && p.wr && (p.rw == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] expSel(input logic [4:0] r, input logic u);
    if (!u) return 2'd0;
    if (hist.size() > 0 && writes(hist[0], r)) return 2'd1;
    if (hist.size() > 1 && writes(hist[1], r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit expHazard(input instr_t i);
    if (!i.valid || hist.size() == 0 || !hist[0].ld) return 1'b0;
    return (i.urs && writes(hist[0], i.rs)) || (i.urt && !i.alusrc && writes(hist[0], i.rt));
  endfunction

  task automatic drive(input instr_t i, input logic busy);
    dut_if.id_valid    = i.valid;
    dut_if.id_rs       = i.rs;
    dut_if.id_rt       = i.rt;
    dut_if.id_use_rs   = i.urs;
    dut_if.id_use_rt   = i.urt;
    dut_if.id_alusrc   = i.alusrc;
    dut_if.id_rw       = i.rw;
    dut_if.id_regwrite = i.wr;
    dut_if.id_memtoreg = i.ld;
    dut_if.mem_busy    = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    drive(noInstr(), 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(alu(5'd3, 5'd1, 5'd2), 1'b1);
    #3;
    nChecks++; if (dut_if.freeze !== 1'b1) begin nFails++; $display("FAIL rst_freeze got %b want 1", dut_if.freeze); end
    nChecks++; if (dut_if.stall_ifid !== 1'b0) begin nFails++; $display("FAIL rst_stall got %b want 0", dut_if.stall_ifid); end
    nChecks++; if (dut_if.bubble_idex !== 1'b0) begin nFails++; $display("FAIL rst_bubble got %b want 0", dut_if.bubble_idex); end
    tick();
    nChecks++; if (dut_if.freeze_cnt !== 32'd0) begin nFails++; $display("FAIL rst_freeze_cnt got %0d want 0", dut_if.freeze_cnt); end
    drive(noInstr(), 1'b0);
    #1;
    nChecks++; if (dut_if.freeze !== 1'b0) begin nFails++; $display("FAIL rst_freeze_low got %b want 0", dut_if.freeze); end
    tick();
    nChecks++; if (dut_if.aluselectA !== 2'd0) begin nFails++; $display("FAIL rst_selA got %0d want 0", dut_if.aluselectA); end
    nChecks++; if (dut_if.aluselectB !== 2'd0) begin nFails++; $display("FAIL rst_selB got %0d want 0", dut_if.aluselectB); end
    nChecks++; if (dut_if.stall_cnt !== 32'd0) begin nFails++; $display("FAIL rst_stall_cnt got %0d want 0", dut_if.stall_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_ex_forward();
    doReset();
    drive(alu(5'd3, 5'd1, 5'd2), 1'b0); tick();
    drive(alu(5'd4, 5'd3, 5'd5), 1'b0); #3;
    nChecks++; if (dut_if.stall_ifid !== 1'b0) begin nFails++; $display("FAIL exfwd_stall got %b want 0", dut_if.stall_ifid); end
    tick();
    nChecks++; if (dut_if.aluselectA !== 2'd1) begin nFails++; $display("FAIL exfwd_selA got %0d want 1", dut_if.aluselectA); end
    nChecks++; if (dut_if.aluselectB !== 2'd0) begin nFails++; $display("FAIL exfwd_selB got %0d want 0", dut_if.aluselectB); end
    drive(alu(5'd6, 5'd1, 5'd4), 1'b0); tick();
    nChecks++; if (dut_if.aluselectB !== 2'd1) begin nFails++; $display("FAIL exfwd_selB2 got %0d want 1", dut_if.aluselectB); end
    nChecks++; if (dut_if.aluselectA !== 2'd0) begin nFails++; $display("FAIL exfwd_selA2 got %0d want 0", dut_if.aluselectA); end
  endtask

  task automatic test_mem_forward();
    doReset();
    drive(alu(5'd3, 5'd1, 5'd2), 1'b0); tick();
    drive(noInstr(), 1'b0); tick();
    drive(alu(5'd6, 5'd7, 5'd3), 1'b0); tick();
    nChecks++; if (dut_if.aluselectB !== 2'd2) begin nFails++; $display("FAIL memfwd_selB got %0d want 2", dut_if.aluselectB); end
    nChecks++; if (dut_if.aluselectA !== 2'd0) begin nFails++; $display("FAIL memfwd_selA got %0d want 0", dut_if.aluselectA); end
    doReset();
    drive(alu(5'd3, 5'd1, 5'd2), 1'b0); tick();
    drive(noInstr(), 1'b0); tick();
    drive(immOp(5'd6, 5'd7, 5'd3), 1'b0); tick();
    nChecks++; if (dut_if.aluselectB !== 2'd0) begin nFails++; $display("FAIL memfwd_imm_selB got %0d want 0", dut_if.aluselectB); end
  endtask

  task automatic test_load_use();
    doReset();
    drive(lw(5'd8, 5'd1), 1'b0); tick();
    drive(alu(5'd9, 5'd8, 5'd1), 1'b0); #3;
    nChecks++; if (dut_if.stall_ifid !== 1'b1) begin nFails++; $display("FAIL lu_stall got %b want 1", dut_if.stall_ifid); end
    nChecks++; if (dut_if.bubble_idex !== 1'b1) begin nFails++; $display("FAIL lu_bubble got %b want 1", dut_if.bubble_idex); end
    tick();
    nChecks++; if (dut_if.aluselectA !== 2'd0) begin nFails++; $display("FAIL lu_bubble_selA got %0d want 0", dut_if.aluselectA); end
    #3;
    nChecks++; if (dut_if.stall_ifid !== 1'b0) begin nFails++; $display("FAIL lu_stall_once got %b want 0", dut_if.stall_ifid); end
    tick();
    nChecks++; if (dut_if.aluselectA !== 2'd2) begin nFails++; $display("FAIL lu_selA got %0d want 2", dut_if.aluselectA); end
    nChecks++; if (dut_if.stall_cnt !== 32'd1) begin nFails++; $display("FAIL lu_stall_cnt got %0d want 1", dut_if.stall_cnt); end
    drive(noInstr(), 1'b0); tick();
    nChecks++; if (dut_if.stall_cnt !== 32'd1) begin nFails++; $display("FAIL lu_stall_cnt_hold got %0d want 1", dut_if.stall_cnt); end
    drive(lw(5'd8, 5'd1), 1'b0); tick();
    drive(alu(5'd9, 5'd1, 5'd8), 1'b0); #3;
    nChecks++; if (dut_if.stall_ifid !== 1'b1) begin nFails++; $display("FAIL lu_rt_stall got %b want 1", dut_if.stall_ifid); end
    tick(); tick();
    nChecks++; if (dut_if.aluselectB !== 2'd2) begin nFails++; $display("FAIL lu_rt_selB got %0d want 2", dut_if.aluselectB); end
    drive(lw(5'd8, 5'd1), 1'b0); tick();
    drive(immOp(5'd9, 5'd1, 5'd8), 1'b0); #3;
    nChecks++; if (dut_if.stall_ifid !== 1'b0) begin nFails++; $display("FAIL lu_imm_stall got %b want 0", dut_if.stall_ifid); end
    tick();
  endtask

  task automatic test_priority_zero();
    doReset();
    drive(alu(5'd2, 5'd1, 5'd1), 1'b0); tick();
    drive(alu(5'd2, 5'd3, 5'd3), 1'b0); tick();
    drive(alu(5'd10, 5'd2, 5'd2), 1'b0); tick();
    nChecks++; if (dut_if.aluselectA !== 2'd1) begin nFails++; $display("FAIL prio_selA got %0d want 1", dut_if.aluselectA); end
    nChecks++; if (dut_if.aluselectB !== 2'd1) begin nFails++; $display("FAIL prio_selB got %0d want 1", dut_if.aluselectB); end
    drive(alu(5'd0, 5'd1, 5'd1), 1'b0); tick();
    drive(alu(5'd11, 5'd0, 5'd0), 1'b0); tick();
    nChecks++; if (dut_if.aluselectA !== 2'd0) begin nFails++; $display("FAIL zero_selA got %0d want 0", dut_if.aluselectA); end
    nChecks++; if (dut_if.aluselectB !== 2'd0) begin nFails++; $display("FAIL zero_selB got %0d want 0", dut_if.aluselectB); end
    drive(lw(5'd0, 5'd1), 1'b0); tick();
    drive(alu(5'd12, 5'd0, 5'd1), 1'b0); #3;
    nChecks++; if (dut_if.stall_ifid !== 1'b0) begin nFails++; $display("FAIL zero_lu_stall got %b want 0", dut_if.stall_ifid); end
    tick();
    nChecks++; if (dut_if.aluselectA !== 2'd0) begin nFails++; $display("FAIL zero_lu_selA got %0d want 0", dut_if.aluselectA); end
  endtask

  task automatic test_freeze();
    doReset();
    drive(alu(5'd1, 5'd2, 5'd3), 1'b0); tick();
    drive(lw(5'd8, 5'd1), 1'b0); tick();
    nChecks++; if (dut_if.aluselectA !== 2'd1) begin nFails++; $display("FAIL frz_pre_selA got %0d want 1", dut_if.aluselectA); end
    for (int c = 0; c < 3; c++) begin
      drive(alu(5'd9, 5'd8, 5'd1), 1'b1); #3;
      nChecks++; if (dut_if.stall_ifid !== 1'b0) begin nFails++; $display("FAIL frz_stall c%0d got %b want 0", c, dut_if.stall_ifid); end
      nChecks++; if (dut_if.bubble_idex !== 1'b0) begin nFails++; $display("FAIL frz_bubble c%0d got %b want 0", c, dut_if.bubble_idex); end
      nChecks++; if (dut_if.freeze !== 1'b1) begin nFails++; $display("FAIL frz_freeze c%0d got %b want 1", c, dut_if.freeze); end
      tick();
      nChecks++; if (dut_if.aluselectA !== 2'd1) begin nFails++; $display("FAIL frz_hold_selA c%0d got %0d want 1", c, dut_if.aluselectA); end
    end
    nChecks++; if (dut_if.freeze_cnt !== 32'd3) begin nFails++; $display("FAIL frz_cnt got %0d want 3", dut_if.freeze_cnt); end
    drive(alu(5'd9, 5'd8, 5'd1), 1'b0); #3;
    nChecks++; if (dut_if.stall_ifid !== 1'b1) begin nFails++; $display("FAIL frz_release_stall got %b want 1", dut_if.stall_ifid); end
    nChecks++; if (dut_if.freeze !== 1'b0) begin nFails++; $display("FAIL frz_release_freeze got %b want 0", dut_if.freeze); end
    tick(); #3;
    nChecks++; if (dut_if.stall_ifid !== 1'b0) begin nFails++; $display("FAIL frz_one_stall got %b want 0", dut_if.stall_ifid); end
    tick();
    nChecks++; if (dut_if.aluselectA !== 2'd2) begin nFails++; $display("FAIL frz_selA got %0d want 2", dut_if.aluselectA); end
    nChecks++; if (dut_if.stall_cnt !== 32'd1) begin nFails++; $display("FAIL frz_stall_cnt got %0d want 1", dut_if.stall_cnt); end
    nChecks++; if (dut_if.freeze_cnt !== 32'd3) begin nFails++; $display("FAIL frz_cnt_after got %0d want 3", dut_if.freeze_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    drive(noInstr(), 1'b1); tick();
    nChecks++; if (dut_if.freeze_cnt !== 32'd1) begin nFails++; $display("FAIL rms_pre_fcnt got %0d want 1", dut_if.freeze_cnt); end
    drive(alu(5'd7, 5'd1, 5'd1), 1'b0); tick();
    drive(lw(5'd8, 5'd7), 1'b0); tick();
    drive(alu(5'd9, 5'd8, 5'd1), 1'b0); #2;
    nChecks++; if (dut_if.stall_ifid !== 1'b1) begin nFails++; $display("FAIL rms_pre_stall got %b want 1", dut_if.stall_ifid); end
    rst_n = 1'b0; #1;
    nChecks++; if (dut_if.aluselectA !== 2'd0) begin nFails++; $display("FAIL rms_selA got %0d want 0", dut_if.aluselectA); end
    nChecks++; if (dut_if.stall_ifid !== 1'b0) begin nFails++; $display("FAIL rms_stall got %b want 0", dut_if.stall_ifid); end
    nChecks++; if (dut_if.bubble_idex !== 1'b0) begin nFails++; $display("FAIL rms_bubble got %b want 0", dut_if.bubble_idex); end
    nChecks++; if (dut_if.freeze_cnt !== 32'd0) begin nFails++; $display("FAIL rms_fcnt got %0d want 0", dut_if.freeze_cnt); end
    tick();
    rst_n = 1'b1; #3;
    nChecks++; if (dut_if.bubble_idex !== 1'b0) begin nFails++; $display("FAIL rms_post_bubble got %b want 0", dut_if.bubble_idex); end
    tick();
    nChecks++; if (dut_if.aluselectA !== 2'd0) begin nFails++; $display("FAIL rms_post_selA got %0d want 0", dut_if.aluselectA); end
    drive(noInstr(), 1'b0); tick();
    nChecks++; if (dut_if.stall_cnt !== 32'd0) begin nFails++; $display("FAIL rms_post_scnt got %0d want 0", dut_if.stall_cnt); end
  endtask

  task automatic test_random();
    instr_t     cur;
    logic       busy;
    bit         haz;
    bit         pending;
    logic [1:0] eA;
    logic [1:0] eB;
    int         eStall;
    int         eFreeze;
    doReset();
    hist.delete();
    pending = 1'b0; eStall = 0; eFreeze = 0; eA = 2'd0; eB = 2'd0;
    cur = randInstr();
    for (int n = 0; n < 800; n++) begin
      busy = ($urandom_range(0, 5) == 0);
      drive(cur, busy);
      #3;
      haz = expHazard(cur);
      nChecks++; if (dut_if.stall_ifid !== (haz && !busy)) begin nFails++; $display("FAIL rnd_stall n%0d got %b want %b", n, dut_if.stall_ifid, haz && !busy); end
      nChecks++; if (dut_if.bubble_idex !== (haz && !busy)) begin nFails++; $display("FAIL rnd_bubble n%0d got %b want %b", n, dut_if.bubble_idex, haz && !busy); end
      nChecks++; if (dut_if.freeze !== busy) begin nFails++; $display("FAIL rnd_freeze n%0d got %b want %b", n, dut_if.freeze, busy); end
      tick();
      if (!busy) begin
        eA = (cur.valid && !haz) ? expSel(cur.rs, cur.urs) : 2'd0;
        eB = (cur.valid && !haz) ? expSel(cur.rt, cur.urt && !cur.alusrc) : 2'd0;
        if (pending) eStall++;
        pending = haz;
        hist.push_front('{valid:cur.valid && !haz, rw:cur.rw, wr:cur.wr, ld:cur.ld});
        if (hist.size() > 2) void'(hist.pop_back());
      end else begin
        eFreeze++;
      end
      nChecks++; if (dut_if.aluselectA !== eA) begin nFails++; $display("FAIL rnd_selA n%0d got %0d want %0d", n, dut_if.aluselectA, eA); end
      nChecks++; if (dut_if.aluselectB !== eB) begin nFails++; $display("FAIL rnd_selB n%0d got %0d want %0d", n, dut_if.aluselectB, eB); end
      nChecks++; if (dut_if.stall_cnt !== 32'(eStall)) begin nFails++; $display("FAIL rnd_stall_cnt n%0d got %0d want %0d", n, dut_if.stall_cnt, eStall); end
      nChecks++; if (dut_if.freeze_cnt !== 32'(eFreeze)) begin nFails++; $display("FAIL rnd_freeze_cnt n%0d got %0d want %0d", n, dut_if.freeze_cnt, eFreeze); end
      if (!busy && !haz) cur = randInstr();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(noInstr(), 1'b0);
    tick();
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_priority_zero();
    test_freeze();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
